// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, fetch bundle type and slot-ordering helpers
package fetch_pkg;

  localparam int FETCH_WIDTH = 4;
  localparam int PC_W        = 15;
  localparam int INSTR_W     = 16;

  typedef logic [FETCH_WIDTH-1:0][INSTR_W-1:0] instr_vec_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    instr_vec_t      instr;
  } fetch_bundle_t;

  // Slot 0 lives in the most significant field of every flat bus.
  function automatic logic [FETCH_WIDTH*INSTR_W-1:0] flatten_instr(input instr_vec_t v);
    logic [FETCH_WIDTH*INSTR_W-1:0] f;
    f = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      f[(FETCH_WIDTH-1-i)*INSTR_W +: INSTR_W] = v[i];
    end
    return f;
  endfunction

  function automatic instr_vec_t unflatten_instr(input logic [FETCH_WIDTH*INSTR_W-1:0] f);
    instr_vec_t v;
    v = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      v[i] = f[(FETCH_WIDTH-1-i)*INSTR_W +: INSTR_W];
    end
    return v;
  endfunction

  // Consecutive word addresses wrap modulo 2^PC_W inside one bundle.
  function automatic logic [FETCH_WIDTH*PC_W-1:0] pc_slots(input logic [PC_W-1:0] base);
    logic [FETCH_WIDTH*PC_W-1:0] f;
    f = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      f[(FETCH_WIDTH-1-i)*PC_W +: PC_W] = base + PC_W'(i);
    end
    return f;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - bundle FIFO with flush, registered head, no bypass
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_bundle_t push_data,
  output logic          full,
  output logic          empty,
  output fetch_bundle_t head
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  fetch_bundle_t mem [DEPTH];

  // Pointer update; flush and reset both empty the queue in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - four-wide fetch engine with queue and redirect; optional FETCH_STATS_EN counters
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [FETCH_WIDTH*PC_W-1:0]      pc_array_flat,
  input  logic [FETCH_WIDTH*INSTR_W-1:0]   instructions_flat,
  input  logic                             redirect_valid,
  input  logic [15:0]                      redirect_pc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [15:0]                      out_pc,
  output logic [FETCH_WIDTH*INSTR_W-1:0]   out_instructions_flat,
  output logic                             fetch_stall
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                      fetch_count,
  output logic [31:0]                      stall_count
`endif
);

  logic [PC_W-1:0] fpc;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  fetch_bundle_t   push_data;
  fetch_bundle_t   head;

  assign out_valid   = !empty;
  assign pop         = out_valid & out_ready;
  assign push        = !redirect_valid & (!full | pop);
  assign fetch_stall = !redirect_valid & full & !pop;

  // The cache sees the current pointer every cycle, even while stalled.
  assign pc_array_flat = pc_slots(fpc);

  // Capture the combinational cache return alongside its fetch address.
  always_comb begin
    push_data.pc    = fpc;
    push_data.instr = unflatten_instr(instructions_flat);
  end

  // Fetch pointer: redirect wins, otherwise advance one bundle per push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc <= RESET_PC[15:1];
    end else if (redirect_valid) begin
      fpc <= redirect_pc[15:1];
    end else if (push) begin
      fpc <= fpc + PC_W'(FETCH_WIDTH);
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .push_data(push_data),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign out_pc                = {head.pc, 1'b0};
  assign out_instructions_flat = flatten_instr(head.instr);

`ifdef FETCH_STATS_EN
  // Free-running statistics; redirect deliberately leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push)        fetch_count <= fetch_count + 32'd1;
      if (fetch_stall) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [59:0] pc_array_flat;
  logic [63:0] instructions_flat;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [63:0] out_instructions_flat;
  logic        fetch_stall;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  instruction_fetch #(
    .DEPTH(4),
    .RESET_PC(16'h0100)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pc_array_flat        (pc_array_flat),
    .instructions_flat    (instructions_flat),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_pc               (out_pc),
    .out_instructions_flat(out_instructions_flat),
    .fetch_stall          (fetch_stall)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count          (fetch_count),
    .stall_count          (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [14:0] a);
    return {a[6:0], a[14:6]} ^ 16'hA5C3;
  endfunction

  function automatic logic [63:0] exp_instr(input logic [15:0] pc_b);
    logic [14:0] w;
    logic [63:0] f;
    w = pc_b[15:1];
    f = '0;
    for (int i = 0; i < 4; i++) f[63-16*i -: 16] = instr_of(w + 15'(i));
    return f;
  endfunction

  // Combinational cache model
  always_comb begin
    instructions_flat = '0;
    for (int i = 0; i < 4; i++)
      instructions_flat[63-16*i -: 16] = instr_of(pc_array_flat[59-15*i -: 15]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head is compared against the scoreboard front
  initial begin
    logic [15:0] p;
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual=%h required=none", out_pc);
        end else begin
          p = exp_q.pop_front();
          check("pop_pc", out_pc, p);
          check("pop_instr", out_instructions_flat, exp_instr(p));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instructions_flat, 0);
    check("rst_stall", fetch_stall, 0);
    check("rst_slots", pc_array_flat, {15'h0080, 15'h0081, 15'h0082, 15'h0083});

    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0108);
    exp_q.push_back(16'h0110);
    exp_q.push_back(16'h0118);
    rst = 1'b0;
    step();
    check("first_valid", out_valid, 1);
    check("first_pc", out_pc, 16'h0100);
    step();
    check("second_pc", out_pc, 16'h0108);
    step();
    check("third_pc", out_pc, 16'h0110);
    step();

    // Back-pressure: fill to DEPTH
    out_ready = 1'b0;
    exp_q.push_back(16'h0120);
    exp_q.push_back(16'h0128);
    exp_q.push_back(16'h0130);
    step();
    step();
    step();
    check("full_stall", fetch_stall, 1);
    check("full_slot0", pc_array_flat[59:45], 15'h009C);
    step();
    check("frozen_stall", fetch_stall, 1);
    check("frozen_slot0", pc_array_flat[59:45], 15'h009C);
    check("frozen_head", out_pc, 16'h0118);

    // Full with pop: push and pop together
    out_ready = 1'b1;
    #1;
    check("fullpop_stall", fetch_stall, 0);
    exp_q.push_back(16'h0138);
    step();
    check("fullpop_slot0", pc_array_flat[59:45], 15'h00A0);
    check("fullpop_head", out_pc, 16'h0120);
    out_ready = 1'b0;
    #1;
    check("count_still_full", fetch_stall, 1);
    step();

    // Redirect while full, with a pop in the redirect cycle
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h2001;
    #1;
    check("redir_stall", fetch_stall, 0);
    step();
    check("redir_valid", out_valid, 0);
    check("redir_slot0", pc_array_flat[59:45], 15'h1000);
    exp_q.delete();
    exp_q.push_back(16'h2000);
    exp_q.push_back(16'h2008);
    redirect_valid = 1'b0;
    step();
    check("redir_target_valid", out_valid, 1);
    check("redir_target_pc", out_pc, 16'h2000);
    step();

    // Wrap within a bundle
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFC;
    step();
    check("wrap_valid", out_valid, 0);
    check("wrap_slots", pc_array_flat, {15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001});
    check("drained_all", exp_q.size(), 0);
    redirect_valid = 1'b0;
    exp_q.push_back(16'hFFFC);
    exp_q.push_back(16'h0004);
    step();
    check("wrap_head", out_pc, 16'hFFFC);
    check("wrap_next_slot0", pc_array_flat[59:45], 15'h0002);
    step();
    check("wrap_next_head", out_pc, 16'h0004);
    out_ready = 1'b0;
    step();
    step();

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_pc", out_pc, 0);
    check("arst_stall", fetch_stall, 0);
    check("arst_slot0", pc_array_flat[59:45], 15'h0080);
`ifdef FETCH_STATS_EN
    check("arst_fetch_count", fetch_count, 0);
    check("arst_stall_count", stall_count, 0);
`endif
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    check("restart_valid", out_valid, 1);
    check("restart_pc", out_pc, 16'h0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch engine that drives the instruction cache's four read ports. Every cycle it presents four consecutive 15-bit word addresses and captures the four 16-bit instructions returned combinationally in the same cycle as one bundle. Bundles are queued in a small FIFO and handed to decode over a valid/ready handshake. A redirect from the back end flushes the queue and restarts fetch at a new PC.

## Interface
- DEPTH, 4, number of bundle entries in the fetch queue; a power of two, at least 2.
- RESET_PC, 16'h0000, byte address fetched after reset; bit 0 is ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- pc_array_flat  out  60  four word addresses; slot i occupies [59-15i:45-15i], so slot 0 is [59:45].
- instructions_flat  in  64  cache data; slot i occupies [63-16i:48-16i].
- redirect_valid  in  1  restart fetch at redirect_pc.
- redirect_pc  in  16  byte address; bit 0 is ignored.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_pc  out  16  byte address of the head bundle's slot 0; bit 0 always reads 0.
- out_instructions_flat  out  64  head bundle, using the same slot layout as instructions_flat.
- fetch_stall  out  1  high when the queue blocks a fetch this cycle.

## Operation
- Fetch pointer fpc[14:0] is a word address. Slot i address = (fpc + i) mod 2^15, so a bundle wraps within itself (e.g. fpc 15'h7ffe gives 7ffe, 7fff, 0000, 0001).
- pop = out_valid & out_ready.
- push = !redirect_valid & (!full | pop). On push:
  - enqueue {fpc, instructions_flat};
  - fpc <= fpc + 4 mod 2^15.
- fetch_stall = !redirect_valid & full & !pop.
- Redirect has priority over everything else:
  - all entries are cleared and count goes to 0;
  - fpc <= redirect_pc[15:1];
  - nothing is pushed that cycle.
  - A pop in the redirect cycle is still a completed transfer. Decode flushes on the same redirect.
- Full with a simultaneous pop: push and pop both occur, and the count is unchanged.
- Empty: out_valid=0, and out_pc and out_instructions_flat read 0.
- pc_array_flat is driven from fpc at all times, including stall cycles; the returned data is simply not captured while stalled.
- Reset values:
  - fpc = RESET_PC[15:1]; queue empty;
  - out_valid=0, out_pc=0, out_instructions_flat=0, fetch_stall=0;
  - pc_array_flat = slot addresses derived from RESET_PC.
- Reset asserted mid-operation discards all queued bundles immediately (asynchronous).

## Timing
- Cache access is combinational, so a bundle is captured at the end of its fetch cycle and appears at the queue head in the next cycle if the queue was empty.
- First bundle after reset deassertion: out_valid=1 one cycle after the first clock edge with rst low.
- Redirect asserted in cycle N:
  - out_valid=0 in cycle N+1;
  - the target bundle is fetched in N+1;
  - out_valid=1 in N+2.
- Sustained throughput: one bundle per cycle while out_ready is held high.
- The FIFO has no bypass path: out_* always come from registered queue storage.

## Configuration
- FETCH_STATS_EN defined:
  - adds output ports fetch_count (out, 32) and stall_count (out, 32);
  - fetch_count increments on each push; stall_count increments on each cycle with fetch_stall=1;
  - both counters reset to 0, wrap at 2^32, and are not cleared by redirect.
- FETCH_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package fetch_pkg holds:
  - FETCH_WIDTH=4, PC_W=15, INSTR_W=16;
  - typedef fetch_bundle_t {pc[14:0], instr[FETCH_WIDTH][15:0]};
  - flatten/unflatten helper functions for the slot ordering.
- Sub-module fetch_queue: parameterised FIFO of fetch_bundle_t, with push, pop, flush, full, empty and head outputs. It owns the read/write pointers (log2(DEPTH)+1 bits each).
- The top level owns fpc, push/stall logic, address generation and the counters.

## Test plan
- Reset with RESET_PC=16'h0100, out_ready=1 -> pc_array_flat slots 0080..0083; first out_pc=0100, then 0108, 0110 in consecutive cycles.
- Hold out_ready=0 with DEPTH=4 -> exactly 4 bundles are queued, then fetch_stall=1 and fpc is frozen. Release -> bundles drain in order with no gaps or duplicates.
- Redirect to 16'h2001 while the queue is full -> next cycle out_valid=0; slot 0 address 15'h1000; following cycle out_pc=2000.
- fpc=15'h7ffe -> slots 7ffe, 7fff, 0000, 0001; the next bundle has fpc=0002.
- Full queue with out_ready=1 and no redirect -> push and pop in the same cycle, fetch_stall=0, count stays 4.
- rst pulsed mid-stream (not on a clock edge) -> out_valid drops immediately and fpc returns to RESET_PC[15:1]. With FETCH_STATS_EN, both counters read 0.
